// File: rtl/instruction_fetch_decode.sv
// Single-outstanding instruction fetch with a one-entry decoded holding stage.
// Fetches from fetch_pc, holds the decoded word until consumed, then redirects or halts.
module instruction_fetch_decode #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic [1:0]  next_pc_selector,
  input  logic        branch_taken,
  input  logic [31:0] target_address,
  output logic        instruction_valid,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        r_type,
  output logic        i_type_lw,
  output logic        i_type_addi,
  output logic        i_type_jalr,
  output logic        s_type,
  output logic        sb_type,
  output logic        u_type_auipc,
  output logic        u_type_lui,
  output logic        uj_type,
  output logic [2:0]  func_3,
  output logic        func_7_bit_6,
  output logic        illegal_instruction,
  output logic        fetch_misaligned,
  output logic [1:0]  dbg_state
);

  // Handshakes: a request transfers on a rising edge where imem_req_valid and
  // imem_req_ready are both high; a response is taken on any edge with
  // imem_rsp_valid high while waiting (never backpressured); the held
  // instruction is consumed on an edge where instruction_valid=1 and stall=0.
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [8:0]  cls_q, cls_d;
  logic [2:0]  f3_q, f3_d;
  logic        f7_q, f7_d;
  logic        ill_q, ill_d;
  logic        mis_q, mis_d;

  logic [8:0]  cls_dec;
  logic        f7_dec;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;

  // Decode straight off the response bus so it is registered together with the word.
  always_comb begin
    cls_dec = '0;
    case (imem_rsp_data[6:0])
      7'b0110011: cls_dec[8] = 1'b1;
      7'b0000011: cls_dec[7] = 1'b1;
      7'b0010011: cls_dec[6] = 1'b1;
      7'b1100111: cls_dec[5] = 1'b1;
      7'b0100011: cls_dec[4] = 1'b1;
      7'b1100011: cls_dec[3] = 1'b1;
      7'b0010111: cls_dec[2] = 1'b1;
      7'b0110111: cls_dec[1] = 1'b1;
      7'b1101111: cls_dec[0] = 1'b1;
      default:    cls_dec    = '0;
    endcase
    f7_dec = imem_rsp_data[30] &
             (cls_dec[8] | (cls_dec[6] & (imem_rsp_data[14:12] == 3'b101)));
  end

  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    case (next_pc_selector)
      2'b00:   next_pc = pc_plus4;
      2'b01:   next_pc = {target_address[31:1], 1'b0};
      2'b10:   next_pc = branch_taken ? target_address : pc_plus4;
      default: next_pc = target_address;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    pc_d           = pc_q;
    instr_d        = instr_q;
    cls_d          = cls_q;
    f3_d           = f3_q;
    f7_d           = f7_q;
    ill_d          = ill_q;
    mis_d          = mis_q;
    imem_req_valid    = 1'b0;
    instruction_valid = 1'b0;
    case (state_q)
      S_REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          instr_d = imem_rsp_data;
          pc_d    = fetch_pc_q;
          cls_d   = cls_dec;
          f3_d    = imem_rsp_data[14:12];
          f7_d    = f7_dec;
          ill_d   = (cls_dec == 9'd0);
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        instruction_valid = 1'b1;
        if (!stall) begin
          fetch_pc_d = next_pc;
          mis_d      = next_pc[1];
          state_d    = (ill_q || next_pc[1]) ? S_HALT : S_REQ;
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      pc_q       <= '0;
      instr_q    <= '0;
      cls_q      <= '0;
      f3_q       <= '0;
      f7_q       <= 1'b0;
      ill_q      <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      cls_q      <= cls_d;
      f3_q       <= f3_d;
      f7_q       <= f7_d;
      ill_q      <= ill_d;
      mis_q      <= mis_d;
    end
  end

  assign imem_addr           = fetch_pc_q;
  assign instruction         = instr_q;
  assign pc                  = pc_q;
  assign {r_type, i_type_lw, i_type_addi, i_type_jalr, s_type,
          sb_type, u_type_auipc, u_type_lui, uj_type} = cls_q;
  assign func_3              = f3_q;
  assign func_7_bit_6        = f7_q;
  assign illegal_instruction = ill_q;
  assign fetch_misaligned    = mis_q;
  assign dbg_state           = state_q;

endmodule

// File: tb/tb_instruction_fetch_decode.sv
// Scoreboard bench for instruction_fetch_decode: directed scenarios plus a
// randomized program walk checked against a plain next-PC/decode model.
module tb_instruction_fetch_decode;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int W = 78;

  logic        clk, rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall;
  logic [1:0]  next_pc_selector;
  logic        branch_taken;
  logic [31:0] target_address;
  logic        instruction_valid;
  logic [31:0] instruction, pc;
  logic        r_type, i_type_lw, i_type_addi, i_type_jalr, s_type;
  logic        sb_type, u_type_auipc, u_type_lui, uj_type;
  logic [2:0]  func_3;
  logic        func_7_bit_6, illegal_instruction, fetch_misaligned;
  logic [1:0]  dbg_state;

  instruction_fetch_decode #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .stall(stall), .next_pc_selector(next_pc_selector),
    .branch_taken(branch_taken), .target_address(target_address),
    .instruction_valid(instruction_valid), .instruction(instruction), .pc(pc),
    .r_type(r_type), .i_type_lw(i_type_lw), .i_type_addi(i_type_addi),
    .i_type_jalr(i_type_jalr), .s_type(s_type), .sb_type(sb_type),
    .u_type_auipc(u_type_auipc), .u_type_lui(u_type_lui), .uj_type(uj_type),
    .func_3(func_3), .func_7_bit_6(func_7_bit_6),
    .illegal_instruction(illegal_instruction),
    .fetch_misaligned(fetch_misaligned), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [31:0]  exp_addr_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  logic [6:0] opc_tbl [9] = '{7'b0110011, 7'b0000011, 7'b0010011, 7'b1100111,
                              7'b0100011, 7'b1100011, 7'b0010111, 7'b0110111,
                              7'b1101111};

  logic [31:0] m_pc, m_hpc, m_instr;
  logic        m_ill, m_mis, m_halted;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: event did not occur", name);
  endtask

  // {classes[8:0] (r,lw,addi,jalr,s,sb,auipc,lui,uj), illegal, func_3, func_7_bit_6}
  function automatic logic [13:0] decode_model(input logic [31:0] ins);
    logic [8:0] cls;
    logic       ill, f7;
    cls = '0;
    for (int i = 0; i < 9; i++)
      if (ins[6:0] == opc_tbl[i]) cls[8-i] = 1'b1;
    ill = (cls == 9'd0);
    f7  = ins[30] && (cls[8] || (cls[6] && ins[14:12] == 3'b101));
    return {cls, ill, ins[14:12], f7};
  endfunction

  function automatic logic [31:0] rand_legal();
    logic [31:0] r;
    r = $urandom();
    return {r[31:7], opc_tbl[$urandom_range(0, 8)]};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_req_valid && imem_req_ready) begin
        if (exp_addr_q.size() == 0) fail_now("unexpected_request");
        else check("imem_addr", W'(imem_addr), W'(exp_addr_q.pop_front()));
      end
      if (instruction_valid && !stall) begin
        if (exp_q.size() == 0) fail_now("unexpected_instruction");
        else check("held_instruction",
                   {pc, instruction, r_type, i_type_lw, i_type_addi, i_type_jalr,
                    s_type, sb_type, u_type_auipc, u_type_lui, uj_type,
                    illegal_instruction, func_3, func_7_bit_6},
                   exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
    exp_q.delete();
    exp_addr_q.delete();
    check("rst_instr_valid", W'(instruction_valid), W'(0));
    check("rst_pc", W'(pc), W'(0));
    check("rst_instruction", W'(instruction), W'(0));
    check("rst_decode", W'({r_type, i_type_lw, i_type_addi, i_type_jalr, s_type, sb_type,
                            u_type_auipc, u_type_lui, uj_type, illegal_instruction,
                            func_3, func_7_bit_6}), W'(0));
    check("rst_misaligned", W'(fetch_misaligned), W'(0));
    check("rst_addr", W'(imem_addr), W'(RESET_PC));
    cyc();
    cyc();
    rst_n = 1'b1;
    m_pc = RESET_PC;
    m_halted = 1'b0;
    m_mis = 1'b0;
    m_ill = 1'b0;
    exp_addr_q.push_back(RESET_PC);
    cyc();
    check("post_rst_req_valid", W'(imem_req_valid), W'(1));
    check("post_rst_addr", W'(imem_addr), W'(RESET_PC));
  endtask

  task automatic fetch_one(input logic [31:0] data, input int rdy_dly, input int rsp_dly);
    logic [13:0] d;
    int k;
    k = 0;
    while (!imem_req_valid && k < 50) begin cyc(); k++; end
    if (!imem_req_valid) begin fail_now("request_timeout"); return; end
    repeat (rdy_dly) cyc();
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0;
    d = decode_model(data);
    exp_q.push_back({m_pc, data, d});
    m_hpc = m_pc;
    m_instr = data;
    m_ill = d[4];
    repeat (rsp_dly) begin imem_rsp_data = $urandom(); cyc(); end
    imem_rsp_valid = 1'b1;
    imem_rsp_data = data;
    cyc();
    imem_rsp_valid = 1'b0;
    imem_rsp_data = $urandom();
  endtask

  task automatic consume(input logic [1:0] sel, input logic taken,
                         input logic [31:0] tgt, input int nstall);
    logic [31:0] nxt;
    int k;
    k = 0;
    while (!instruction_valid && k < 50) begin cyc(); k++; end
    if (!instruction_valid) begin fail_now("hold_timeout"); return; end
    repeat (nstall) begin
      imem_rsp_valid = 1'($urandom_range(0, 1));
      imem_req_ready = 1'($urandom_range(0, 1));
      imem_rsp_data  = $urandom();
      cyc();
      check("stall_req_valid", W'(imem_req_valid), W'(0));
      check("stall_instr_valid", W'(instruction_valid), W'(1));
      check("stall_instruction", W'(instruction), W'(m_instr));
      check("stall_pc", W'(pc), W'(m_hpc));
    end
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    case (sel)
      2'd0: nxt = m_hpc + 32'd4;
      2'd1: nxt = tgt & 32'hFFFF_FFFE;
      2'd2: nxt = taken ? tgt : m_hpc + 32'd4;
      default: nxt = tgt;
    endcase
    m_mis = nxt[1];
    m_halted = m_ill || nxt[1];
    if (!m_halted) begin
      exp_addr_q.push_back(nxt);
      m_pc = nxt;
    end
    next_pc_selector = sel;
    branch_taken = taken;
    target_address = tgt;
    stall = 1'b0;
    cyc();
    stall = 1'b1;
  endtask

  task automatic halt_check(input int n);
    repeat (n) begin
      cyc();
      check("halt_req_valid", W'(imem_req_valid), W'(0));
      check("halt_instr_valid", W'(instruction_valid), W'(0));
    end
    check("halt_misaligned", W'(fetch_misaligned), W'(m_mis));
    check("halt_illegal", W'(illegal_instruction), W'(m_ill));
    check("halt_instruction", W'(instruction), W'(m_instr));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] tgt, r;
    logic [1:0]  sel;
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    stall = 1'b1;
    next_pc_selector = 2'd0;
    branch_taken = 1'b0;
    target_address = '0;
    m_instr = '0;
    m_hpc = '0;
    cyc();
    do_reset();

    // sequential fetch, then a 5-cycle stall
    fetch_one(32'h0050_0093, 0, 0);
    consume(2'd0, 1'b0, 32'h0, 0);
    fetch_one(32'h4020_8133, 1, 2);
    consume(2'd0, 1'b0, 32'h0, 5);

    // redirects around pc=0x100
    fetch_one(rand_legal(), 0, 1); consume(2'd3, 1'b0, 32'h100, 0);
    fetch_one(rand_legal(), 0, 0); consume(2'd2, 1'b0, 32'h200, 0);
    fetch_one(rand_legal(), 0, 0); consume(2'd3, 1'b0, 32'h100, 0);
    fetch_one(rand_legal(), 0, 0); consume(2'd2, 1'b1, 32'h200, 0);
    fetch_one(rand_legal(), 0, 0); consume(2'd3, 1'b0, 32'h100, 0);
    fetch_one(rand_legal(), 0, 0); consume(2'd1, 1'b0, 32'h201, 0);
    fetch_one(rand_legal(), 0, 0); consume(2'd3, 1'b0, 32'h100, 0);
    fetch_one(rand_legal(), 0, 0); consume(2'd3, 1'b0, 32'h206, 1);
    halt_check(4);

    // wrap-around
    do_reset();
    fetch_one(rand_legal(), 0, 0); consume(2'd3, 1'b0, 32'hFFFF_FFFC, 0);
    fetch_one(rand_legal(), 0, 0); consume(2'd0, 1'b0, 32'h0, 0);
    fetch_one(rand_legal(), 0, 0); consume(2'd0, 1'b0, 32'h0, 0);

    // randomized program walk (aligned targets, legal opcodes)
    for (int i = 0; i < 40; i++) begin
      fetch_one(rand_legal(), $urandom_range(0, 2), $urandom_range(0, 3));
      sel = 2'($urandom_range(0, 3));
      r = $urandom();
      tgt = r & 32'hFFFF_FFFC;
      if (sel == 2'd1) tgt = tgt | {31'd0, r[0]};
      consume(sel, 1'($urandom_range(0, 1)), tgt, $urandom_range(0, 2));
    end

    // illegal opcode
    do_reset();
    fetch_one(32'hFFFF_FFFF, 0, 0);
    consume(2'd0, 1'b0, 32'h0, 1);
    halt_check(3);

    // reset in the middle of an outstanding fetch
    do_reset();
    fetch_one(32'h0000_0037, 0, 0);
    consume(2'd3, 1'b0, 32'h40, 0);
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0;
    cyc();
    do_reset();
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h0050_0093;
    cyc();
    imem_rsp_valid = 1'b0;
    repeat (3) begin
      check("rstwait_instr_valid", W'(instruction_valid), W'(0));
      check("rstwait_instruction", W'(instruction), W'(0));
      cyc();
    end
    check("rstwait_addr", W'(imem_addr), W'(RESET_PC));
    check("rstwait_req_valid", W'(imem_req_valid), W'(1));
    fetch_one(32'h0000_0013, 0, 1);
    consume(2'd0, 1'b0, 32'h0, 0);
    repeat (3) cyc();

    if (exp_q.size() != 0) fail_now("instructions_not_presented");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_decode.md
INSTRUCTION_FETCH_DECODE -- requirements
Module: instruction_fetch_decode

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 imem_req_valid  output  1 / imem_req_ready  input  1  fetch request handshake; transfer occurs when both are high.
REQ-005 imem_addr  output  32  fetch address; valid while imem_req_valid is high.
REQ-006 imem_rsp_valid  input  1 / imem_rsp_data  input  32  fetch response; there is no backpressure on it.
REQ-007 stall  input  1  downstream hold; the held instruction is consumed on a cycle with instruction_valid=1 and stall=0.
REQ-008 next_pc_selector  input  2, branch_taken  input  1, target_address  input  32  next-PC control from the downstream stage for the held instruction.
REQ-009 instruction_valid  output  1; instruction  output  32; pc  output  32  the held instruction and its address.
REQ-010 r_type, i_type_lw, i_type_addi, i_type_jalr, s_type, sb_type, u_type_auipc, u_type_lui, uj_type  outputs  1 each  one-hot instruction class.
REQ-011 func_3  output  3; func_7_bit_6  output  1; illegal_instruction  output  1; fetch_misaligned  output  1.

Function
REQ-012 FSM states: REQ, WAIT, HOLD, HALT; exactly one request is outstanding at any time.
REQ-013 REQ: imem_req_valid=1 and imem_addr=fetch_pc; move to WAIT on the handshake, otherwise stay in REQ.
REQ-014 WAIT: on imem_rsp_valid, register imem_rsp_data into instruction, fetch_pc into pc, and all decode outputs, then move to HOLD; otherwise stay in WAIT.
REQ-015 HOLD: instruction_valid=1; all held outputs stay stable while stall=1.
REQ-016 HOLD with stall=0: update fetch_pc per REQ-017, then go to REQ. If illegal_instruction or a misaligned target applies, go to HALT instead.
REQ-017 Next PC by next_pc_selector:
- 00: pc+4.
- 01 (jalr): target_address with bit0 cleared.
- 10: target_address if branch_taken, else pc+4.
- 11 (jal): target_address.
- All sums are modulo 2^32 (wrap).
REQ-018 If the selected next PC has bit1 set, fetch_misaligned=1 and the FSM enters HALT.
REQ-019 HALT: imem_req_valid=0 and instruction_valid=0; the block stays in HALT until reset; flags and the held instruction are retained.
REQ-020 Decode by opcode instruction[6:0]:
- 0110011 r_type; 0000011 i_type_lw; 0010011 i_type_addi; 1100111 i_type_jalr; 0100011 s_type.
- 1100011 sb_type; 0010111 u_type_auipc; 0110111 u_type_lui; 1101111 uj_type.
- Any other opcode: all class flags 0 and illegal_instruction=1.
REQ-021 func_3 = instruction[14:12] for every opcode.
REQ-022 func_7_bit_6 = instruction[30] only when r_type, or when i_type_addi with func_3=101; otherwise 0.
REQ-023 instruction_valid is 0 in REQ, WAIT and HALT; decode outputs keep their last registered values outside HOLD.
REQ-024 imem_rsp_valid is ignored in REQ, HOLD and HALT; imem_req_ready is ignored outside REQ.

Reset
REQ-025 When rst_n is low, regardless of clock, the block SHALL immediately force:
- state=REQ, fetch_pc=RESET_PC, pc=0, instruction=0;
- all class flags, func_3, func_7_bit_6, illegal_instruction, fetch_misaligned and instruction_valid = 0.
REQ-026 Reset asserted mid-transaction discards the outstanding request; a response arriving after reset release is ignored per REQ-024.
REQ-027 On the first clock after reset release: imem_req_valid=1 and imem_addr=RESET_PC.

Verification
REQ-028 Sequential fetch:
- Stimulus: ready=1; responses 0x00500093 then 0x40208133; selector=00; stall=0.
- Required: pc 0x0 then 0x4; first i_type_addi=1, func_3=000, func_7_bit_6=0; second r_type=1, func_7_bit_6=1.
REQ-029 Stall:
- Stimulus: HOLD, stall=1 for 5 cycles.
- Required: outputs unchanged and imem_req_valid=0 throughout; next request only after stall=0.
REQ-030 Redirects (pc=0x100, target=0x200):
- selector 10, branch_taken=0 -> next imem_addr 0x104; branch_taken=1 -> 0x200.
- selector 01 with target 0x201 -> 0x200.
- selector 11 with target 0x206 -> fetch_misaligned=1, HALT, no further requests.
REQ-031 Illegal opcode:
- Stimulus: response 0xFFFFFFFF.
- Required: illegal_instruction=1, all class flags 0; HALT after consumption.
REQ-032 Reset mid-WAIT:
- Stimulus: rst_n low during WAIT; rsp_valid arrives 1 cycle after release.
- Required: response ignored; imem_addr=RESET_PC; instruction_valid stays 0.
REQ-033 Wrap-around:
- Stimulus: pc=0xFFFFFFFC, selector=00.
- Required: next imem_addr 0x00000000.
